aco_frame_fifo: RTL
===================

# aco_frame_fifo

Elastic frame buffer between the acoustic featurizer (ACO) and the word-recognition accelerator (WRD) inside `wakey_wakey`. ACO emits 104-bit feature vectors (13 × 8-bit MFCC coefficients) with `valid`/`last` and cannot be stalled. WRD accepts vectors only when its `ready` is high. This block absorbs that mismatch. On overflow it drops the rest of the current frame, always delivers a `last` marker so WRD's frame framing stays intact, and reports the loss.

## Interface
- `DATA_BW`, 104, feature vector width
- `DEPTH`, 16, number of entries; must be a power of two, at least 2
- `ADDR_BW`, 4, log2(`DEPTH`)
- `clk_i`  in  1  system clock
- `rst_i`  in  1  reset; asynchronous, active-high
- `en_i`  in  1  write enable; when low, input beats are ignored and not counted as drops
- `data_i`  in  `DATA_BW`  ACO vector
- `valid_i`  in  1  ACO beat valid; no backpressure
- `last_i`  in  1  final vector of the ACO frame
- `data_o`  out  `DATA_BW`  head vector to WRD; forced to 0 when `valid_o` is 0
- `valid_o`  out  1  FIFO non-empty
- `last_o`  out  1  last flag of the head entry; forced to 0 when `valid_o` is 0
- `ready_i`  in  1  WRD ready; a pop occurs when `valid_o && ready_i`
- `level_o`  out  `ADDR_BW+1`  current occupancy, 0..`DEPTH`
- `overflow_o`  out  1  sticky flag; set by any dropped beat
- `clr_overflow_i`  in  1  clears `overflow_o` and `drop_cnt_o`
- `drop_cnt_o`  out  16  count of dropped beats; saturates at 0xFFFF

## Operation
- **Storage**
  - Flop array of `DEPTH` × (`DATA_BW`+1). The extra bit is the per-entry last flag.
  - Read pointer, write pointer and count are registered. Pointers wrap modulo `DEPTH`.
- **Accept rule**
  - A write occurs only if `en_i && valid_i`, state is PASS (or the beat qualifies as a DROP terminator), and `count < DEPTH` at the start of the cycle.
  - A pop in the same cycle does not free space for a write when `count == DEPTH`.
- **Simultaneous push and pop**
  - With 0 < count < `DEPTH`: count is unchanged and both pointers advance.
  - With count == 0: only the push takes effect. No write-through to the output in the same cycle.
- **State machine**, two states, reset state PASS:
  - PASS, beat arrives with count < `DEPTH`: write the beat with its `last_i` flag; stay in PASS.
  - PASS, beat arrives with count == `DEPTH` and `last_i` = 0: drop the beat; go to DROP.
  - PASS, beat arrives with count == `DEPTH` and `last_i` = 1: drop the beat and set the last flag of entry `wr_ptr-1`; stay in PASS.
  - DROP, beat with `last_i` = 0: drop the beat regardless of occupancy; stay in DROP.
  - DROP, beat with `last_i` = 1 and count < `DEPTH`: write the beat with last = 1; go to PASS. This delivers the truncated frame's terminator.
  - DROP, beat with `last_i` = 1 and count == `DEPTH`: drop the beat, set the last flag of entry `wr_ptr-1`, go to PASS.
- **Why marking `wr_ptr-1` is safe**
  - When count == `DEPTH`, entry `wr_ptr-1` is guaranteed unread, so marking it is legal.
  - If that entry already carries last, marking it is a no-op.
- **Drop accounting**
  - Every dropped beat sets `overflow_o` and increments `drop_cnt_o` (saturating).
  - `clr_overflow_i` zeroes both. If a drop happens in the same cycle as the clear, the clear wins, then the drop applies: `overflow_o` = 1 and `drop_cnt_o` = 1.
- **`en_i` low**
  - Writes are blocked and the state is held.
  - Reads continue, so the FIFO drains normally.

## Timing
- **Reset values**: `valid_o` 0, `last_o` 0, `data_o` 0, `level_o` 0, `overflow_o` 0, `drop_cnt_o` 0; pointers 0; state PASS.
  - Storage contents need not be reset, because the outputs are gated by `valid_o`.
- **Asynchronous reset mid-frame**: all in-flight entries are discarded. Once reset deasserts, the next accepted beat is treated as a new frame in PASS.
- **Latency**: a beat accepted at edge N appears on `data_o`/`valid_o` after edge N, i.e. one cycle, when the FIFO was empty.
- **Pop and output update**
  - A pop at edge N presents the next entry, or `valid_o` = 0, after edge N.
  - Back-to-back pops every cycle are supported.
- **Registered paths**: all outputs are driven from registers. There is no combinational path from `ready_i` or `valid_i` to any output.
- **`level_o` timing**: reflects the count after the last edge.

## Test plan
- **Pass-through**: with `ready_i` = 1, send a 3-beat frame 0xA, 0xB, 0xC, last on 0xC → outputs one cycle later in order, `last_o` = 1 only with 0xC, `level_o` peaks at 1, `overflow_o` = 0.
- **Fill and full-cycle hold**: with `ready_i` = 0, push 16 beats → `level_o` = 16. Then push beat 17 while simultaneously popping → beat 17 dropped, `level_o` = 15, `drop_cnt_o` = 1.
- **Truncation via DROP**
  - Stimulus: with `ready_i` = 0 push 18 beats of one frame, then raise `ready_i` and let 2 entries drain, then send beats 19 and 20 with last on 20.
  - Required: beats 17–19 dropped (`drop_cnt_o` = 3), beat 20 is written with `last_o` = 1, and the output sequence is beats 1–16 then beat 20.
- **Last-beat overflow at full**: with `ready_i` = 0, push 16 beats with no last, then a 17th with `last_i` = 1 → entry 16 pops with `last_o` = 1, `drop_cnt_o` = 1, state PASS; the next frame is accepted normally.
- **Reset mid-frame**: push 5 beats, assert `rst_i` asynchronously between edges → `valid_o` and `level_o` drop to 0 immediately; a fresh frame after reset passes intact.
- **Clear and `en_i`**
  - Pulse `clr_overflow_i` → `overflow_o` = 0 and `drop_cnt_o` = 0 next cycle.
  - Hold `en_i` = 0 while sending 4 beats → none stored, `drop_cnt_o` unchanged.

Source files
------------

// File: rtl/aco_frame_fifo.sv
// Elastic frame buffer between the acoustic featurizer and the word recognizer.
// On overflow it truncates the current frame but always delivers a last marker.
module aco_frame_fifo #(
  parameter int DATA_BW = 104,
  parameter int DEPTH   = 16,
  parameter int ADDR_BW = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [DATA_BW-1:0] data_i,
  input  logic               valid_i,
  input  logic               last_i,
  output logic [DATA_BW-1:0] data_o,
  output logic               valid_o,
  output logic               last_o,
  input  logic               ready_i,
  output logic [ADDR_BW:0]   level_o,
  output logic               overflow_o,
  input  logic               clr_overflow_i,
  output logic [15:0]        drop_cnt_o
);

  typedef enum logic {PASS, DROP} state_t;

  state_t               state_q, state_d;
  logic [DATA_BW-1:0]   mem_data_q [DEPTH];
  logic [DEPTH-1:0]     mem_last_q;
  logic [ADDR_BW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_BW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_BW-1:0]   mark_idx;
  logic [ADDR_BW:0]     count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;

  logic full, beat, pop, wr, drop, mark;

  assign full     = (count_q == (ADDR_BW+1)'(DEPTH));
  assign beat     = en_i && valid_i;
  assign pop      = (count_q != '0) && ready_i;
  assign mark_idx = wr_ptr_q - ADDR_BW'(1);

  // Full FIFO: the newest entry is unread, so it can carry the truncated frame's last flag.
  always_comb begin
    state_d = state_q;
    wr      = 1'b0;
    drop    = 1'b0;
    mark    = 1'b0;
    if (beat) begin
      case (state_q)
        PASS: begin
          if (!full) begin
            wr = 1'b1;
          end else begin
            drop = 1'b1;
            if (last_i) mark = 1'b1;
            else        state_d = DROP;
          end
        end
        DROP: begin
          if (!last_i) begin
            drop = 1'b1;
          end else begin
            state_d = PASS;
            if (!full) begin
              wr = 1'b1;
            end else begin
              drop = 1'b1;
              mark = 1'b1;
            end
          end
        end
        default: state_d = PASS;
      endcase
    end
  end

  always_comb begin
    rd_ptr_d = pop ? rd_ptr_q + ADDR_BW'(1) : rd_ptr_q;
    wr_ptr_d = wr  ? wr_ptr_q + ADDR_BW'(1) : wr_ptr_q;
    count_d  = count_q;
    if (wr && !pop)      count_d = count_q + (ADDR_BW+1)'(1);
    else if (!wr && pop) count_d = count_q - (ADDR_BW+1)'(1);
  end

  // A clear in the same cycle as a drop restarts the tally at that drop.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clr_overflow_i) begin
      overflow_d = drop;
      drop_cnt_d = drop ? 16'd1 : 16'd0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= PASS;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is never reset; outputs are gated by occupancy instead.
  always_ff @(posedge clk_i) begin
    if (wr) begin
      mem_data_q[wr_ptr_q] <= data_i;
      mem_last_q[wr_ptr_q] <= last_i;
    end
    if (mark) mem_last_q[mark_idx] <= 1'b1;
  end

  assign valid_o    = (count_q != '0);
  assign data_o     = valid_o ? mem_data_q[rd_ptr_q] : '0;
  assign last_o     = valid_o ? mem_last_q[rd_ptr_q] : 1'b0;
  assign level_o    = count_q;
  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule
